// File: rtl/mmio_uart_tx_if.sv
// Device-bus interface shared by the MMU and its memory-mapped responders.
// addr is the device-local word index; rd is combinational from addr.
interface mmap_dev;
    logic [29:0] addr;
    logic        re;
    logic [31:0] rd;
    logic        we;
    logic [31:0] wd;

    modport slave (
        input  addr,
        input  re,
        input  we,
        input  wd,
        output rd
    );

    modport master (
        output addr,
        output re,
        output we,
        output wd,
        input  rd
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// Ports: clk, rst_n (async, active-low), bus (mmap_dev.slave), tx (idle high).
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic   clk,
    input  logic   rst_n,
    mmap_dev.slave bus,
    output logic   tx
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   level;
    logic          ovf;
    logic [15:0]   div, div_eff;
    logic [15:0]   per, per_n;
    logic [15:0]   cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic [2:0]    bitn, bitn_n;
    logic          tx_n;
    logic          empty, full, busy;
    logic          push, pop, accept, overflow;
    logic          clr_ovf, div_we;
    logic [3:0]    lvl4;
    logic          unused_bits;

    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign busy     = (state != IDLE);
    assign lvl4     = 4'(level);
    assign div_eff  = (div == 16'd0) ? 16'd1 : div;

    assign push     = bus.we && (bus.addr[1:0] == 2'd0);
    assign clr_ovf  = bus.we && (bus.addr[1:0] == 2'd1) && bus.wd[3];
    assign div_we   = bus.we && (bus.addr[1:0] == 2'd2);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign accept   = push && (!full || pop);
    assign overflow = push && full && !pop;

    assign unused_bits = ^{bus.re, bus.addr[29:2], bus.wd[31:16]};

    always_comb begin
        bus.rd = 32'd0;
        case (bus.addr[1:0])
            2'd1:    bus.rd = {20'd0, lvl4, 4'd0, ovf, busy, full, empty};
            2'd2:    bus.rd = {16'd0, div};
            default: bus.rd = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= bus.wd[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            div   <= DEFAULT_DIV;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (overflow)     ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
            if (div_we) div <= bus.wd[15:0];
        end
    end

    // tx_n is the line level for the cycle after the edge, so tx itself
    // comes straight from a flop.
    always_comb begin
        state_n = state;
        per_n   = per;
        cnt_n   = cnt;
        sh_n    = sh;
        bitn_n  = bitn;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rptr];
                    per_n   = div_eff;
                    cnt_n   = div_eff - 16'd1;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (cnt != 16'd0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    cnt_n   = per - 16'd1;
                    bitn_n  = 3'd0;
                    state_n = DATA;
                    tx_n    = sh[0];
                end
            end
            DATA: begin
                if (cnt != 16'd0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    cnt_n = per - 16'd1;
                    sh_n  = {1'b0, sh[7:1]};
                    if (bitn == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bitn_n = bitn + 3'd1;
                        tx_n   = sh[1];
                    end
                end
            end
            STOP: begin
                if (cnt != 16'd0) begin
                    cnt_n = cnt - 16'd1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rptr];
                    per_n   = div_eff;
                    cnt_n   = div_eff - 16'd1;
                    state_n = START;
                    tx_n    = 1'b0;
                end else begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            per   <= 16'd1;
            cnt   <= 16'd0;
            sh    <= 8'd0;
            bitn  <= 3'd0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            per   <= per_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            bitn  <= bitn_n;
            tx    <= tx_n;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a tx-line monitor pops expected
// bytes (with their bit period) from a scoreboard and checks each frame.
module tb_mmio_uart_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;

    mmap_dev bus ();

    mmio_uart_tx #(
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         p;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   in_frame = 1'b0;
    int   idle_run = 1000;
    int   b2b = 0;

    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        logic       eb;
        int         errs;
        int         p;
        int         idx;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: saw start bit, required idle line");
                    for (int i = 0; i < 20000 && tx !== 1'b1; i++) @(negedge clk);
                end else begin
                    e = sb.pop_front();
                    p = e.p;
                    in_frame = 1'b1;
                    errs = 0;
                    got = 8'h00;
                    if (idle_run == 0) b2b++;
                    for (int k = 0; k < 10 * p; k++) begin
                        if (k > 0) @(negedge clk);
                        idx = k / p;
                        if (idx == 0) eb = 1'b0;
                        else if (idx == 9) eb = 1'b1;
                        else eb = e.b[idx-1];
                        if (tx !== eb) errs++;
                        if (idx >= 1 && idx <= 8 && (k % p) == p / 2)
                            got[idx-1] = tx;
                    end
                    n_cmp++;
                    if (got !== e.b) begin
                        n_bad++;
                        $display("FAIL frame_data: got %02h required %02h", got, e.b);
                    end
                    n_cmp++;
                    if (errs != 0) begin
                        n_bad++;
                        $display("FAIL frame_timing: byte %02h P=%0d got %0d bad samples required 0",
                                 e.b, p, errs);
                    end
                    in_frame = 1'b0;
                    idle_run = 0;
                end
            end else begin
                idle_run++;
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = {28'd0, a};
        bus.wd   = d;
        bus.we   = 1'b1;
        @(negedge clk);
        bus.we   = 1'b0;
        bus.wd   = 32'd0;
    endtask

    task automatic rd_now(input logic [1:0] a, output logic [31:0] d);
        bus.addr = {28'd0, a};
        bus.re   = 1'b1;
        #1;
        d = bus.rd;
        bus.re = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_now(a, d);
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && !in_frame) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d frames pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tx: got %b required 1", tx);
        end
        rst_n = 1'b1;
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++;
            $display("FAIL reset_status: got %08h required 00000001", d);
        end
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd868) begin
            n_bad++;
            $display("FAIL reset_div: got %08h required %08h", d, 32'd868);
        end
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL data_read: got %08h required 0", d);
        end
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL reserved_read: got %08h required 0", d);
        end
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++;
            $display("FAIL reserved_write: status %08h required 00000001", d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int busy_cnt;
        wr(2'd2, 32'd4);
        mon_en = 1'b1;
        sb.push_back('{8'h55, 4});
        wr(2'd0, 32'h55);
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_idle: tx %b required 1", tx);
        end
        rd_now(2'd1, d);
        n_cmp++;
        if (d !== 32'h100) begin
            n_bad++;
            $display("FAIL status_queued: got %08h required 00000100", d);
        end
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            rd(2'd1, d);
            if (i == 0) begin
                n_cmp++;
                if (tx !== 1'b0) begin
                    n_bad++;
                    $display("FAIL latency_start: tx %b required 0", tx);
                end
            end
            if (d[2]) busy_cnt++;
        end
        n_cmp++;
        if (busy_cnt != 40) begin
            n_bad++;
            $display("FAIL busy_cycles: got %0d required 40", busy_cnt);
        end
        wait_idle(200);
    endtask

    task automatic test_sub_word();
        logic [31:0] d;
        logic [31:0] s;
        rd(2'd0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL rmw_read: got %08h required 0", d);
        end
        rd(2'd1, s);
        n_cmp++;
        if (s !== 32'h1) begin
            n_bad++;
            $display("FAIL rmw_no_push: status %08h required 00000001", s);
        end
        sb.push_back('{8'hA5, 4});
        wr(2'd0, (d & 32'hFFFF_FF00) | 32'h0000_00A5);
        wait_idle(200);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        wr(2'd2, 32'd2);
        b2b = 0;
        @(negedge clk);
        bus.addr = 30'd0;
        bus.we   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wd = 32'h10 + 32'(i);
            if (i < 9) sb.push_back('{8'(8'h10 + i), 2});
            @(negedge clk);
        end
        bus.we = 1'b0;
        bus.wd = 32'd0;
        rd_now(2'd1, d);
        n_cmp++;
        if (d !== 32'h80E) begin
            n_bad++;
            $display("FAIL ovf_status: got %08h required 0000080e", d);
        end
        wr(2'd1, 32'h8);
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'h806) begin
            n_bad++;
            $display("FAIL ovf_clear: got %08h required 00000806", d);
        end
        wait_idle(400);
        n_cmp++;
        if (b2b != 8) begin
            n_bad++;
            $display("FAIL contiguous_burst: got %0d gapless frames required 8", b2b);
        end
    endtask

    task automatic test_div();
        logic [31:0] d;
        wr(2'd2, 32'd0);
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL div_zero_read: got %08h required 0", d);
        end
        sb.push_back('{8'h3C, 1});
        wr(2'd0, 32'h3C);
        wait_idle(100);
        wr(2'd2, 32'd2);
        sb.push_back('{8'hC3, 2});
        sb.push_back('{8'h5A, 8});
        wr(2'd0, 32'hC3);
        wr(2'd0, 32'h5A);
        wr(2'd2, 32'd8);
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd8) begin
            n_bad++;
            $display("FAIL div_mid_frame: got %08h required 00000008", d);
        end
        wait_idle(400);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lows;
        mon_en = 1'b0;
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h00);
        wr(2'd0, 32'hFF);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_abort_data: tx %b required 0", tx);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin
            n_bad++;
            $display("FAIL async_abort: tx %b required 1", tx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd(2'd1, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++;
            $display("FAIL abort_status: got %08h required 00000001", d);
        end
        rd(2'd2, d);
        n_cmp++;
        if (d !== 32'd868) begin
            n_bad++;
            $display("FAIL abort_div: got %08h required %08h", d, 32'd868);
        end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++;
            $display("FAIL queue_flushed: got %0d low cycles required 0", lows);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        wr(2'd2, 32'd3);
        b2b = 0;
        sb.push_back('{8'h81, 3});
        sb.push_back('{8'h7E, 3});
        wr(2'd0, 32'h81);
        wr(2'd0, 32'h7E);
        wait_idle(200);
        n_cmp++;
        if (b2b != 1) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d gapless frames required 1", b2b);
        end
    endtask

    initial begin
        bus.addr = 30'd0;
        bus.re   = 1'b0;
        bus.we   = 1'b0;
        bus.wd   = 32'd0;
        test_reset();
        test_basic();
        test_sub_word();
        test_overflow();
        test_div();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
